stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_fifo_mem.sv | 26 ++
 rtl/stream_fifo.sv | 91 +++++++++
 tb/tb_stream_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared flag bit positions and bus widths for the valid/busy/abort stream
// handshake used by stream_fifo and its neighbours.
package stream_pkg;

  localparam int MF_W     = 4;
  localparam int SF_W     = 2;

  localparam int MF_AGAIN = 3;
  localparam int MF_FIRST = 2;
  localparam int MF_LAST  = 1;
  localparam int MF_VLD   = 0;

  localparam int SF_ABT   = 1;
  localparam int SF_BSY   = 0;

endpackage

// File: rtl/stream_fifo_mem.sv
// Entry storage for stream_fifo: one synchronous write port and one
// asynchronous read port, contents deliberately left unreset.
module stream_fifo_mem #(
  parameter int DW    = 34,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Small stream FIFO with valid/busy/abort handshake on both sides; pointer,
// occupancy and handshake control live here, storage in stream_fifo_mem.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    uc_d0,
  input  logic [MF_W-1:0] uc_mflags,
  output logic [SF_W-1:0] cu_sflags,
  output logic [W-1:0]    cd_d0,
  output logic [MF_W-1:0] cd_mflags,
  input  logic [SF_W-1:0] dc_sflags,
  output logic [AW:0]     occ
);

  localparam int DW = W + 2;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;

  logic          w_full;
  logic          w_empty;
  logic          w_abt;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;

  assign w_full  = (r_occ == FULL_CNT);
  assign w_empty = (r_occ == '0);
  assign w_abt   = dc_sflags[SF_ABT];

  // Busy comes from registered occupancy only, so a full FIFO refuses a push
  // even when the downstream pops in the same cycle.
  assign w_push = uc_mflags[MF_VLD] & ~uc_mflags[MF_AGAIN] & ~w_full & ~w_abt;
  assign w_pop  = ~w_empty & ~dc_sflags[SF_BSY] & ~w_abt;

  assign w_wdata = {uc_mflags[MF_FIRST], uc_mflags[MF_LAST], uc_d0};

  stream_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || w_abt) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_ONE;
        2'b01:   r_occ <= r_occ - OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Unreset storage may hold stale data, so the head is masked while empty.
  assign cd_d0     = w_empty ? '0 : w_rdata[W-1:0];
  assign cd_mflags = {1'b0,
                      w_rdata[W+1] & ~w_empty,
                      w_rdata[W]   & ~w_empty,
                      ~w_empty};
  assign cu_sflags = {w_abt, w_full};
  assign occ       = r_occ;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: fill/drain, again-drop, streaming,
// abort flush, pointer wrap and mid-operation reset.
module tb_stream_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst;
  logic [W-1:0]  uc_d0;
  logic [3:0]    uc_mflags;
  logic [1:0]    cu_sflags;
  logic [W-1:0]  cd_d0;
  logic [3:0]    cd_mflags;
  logic [1:0]    dc_sflags;
  logic [AW:0]   occ;

  int n_cmp = 0;
  int n_err = 0;

  stream_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uc_d0     (uc_d0),
    .uc_mflags (uc_mflags),
    .cu_sflags (cu_sflags),
    .cd_d0     (cd_d0),
    .cd_mflags (cd_mflags),
    .dc_sflags (dc_sflags),
    .occ       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] fill_vals [4];
  logic [3:0]   exp_mf;

  initial begin
    fill_vals[0] = 32'h11; fill_vals[1] = 32'h22;
    fill_vals[2] = 32'h33; fill_vals[3] = 32'h44;

    rst = 1'b1; uc_d0 = '0; uc_mflags = 4'b0000; dc_sflags = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("reset_occ", 64'(occ), 64'd0);
    check("reset_cd_mflags", 64'(cd_mflags), 64'h0);
    check("reset_cu_sflags", 64'(cu_sflags), 64'h0);
    check("reset_cd_d0", 64'(cd_d0), 64'h0);

    // Fill while downstream is busy
    dc_sflags = 2'b01;
    for (int i = 0; i < 4; i++) begin
      uc_d0 = fill_vals[i]; uc_mflags = 4'b0001;
      cyc();
      check($sformatf("fill_occ_%0d", i), 64'(occ), 64'(i + 1));
    end
    check("full_cu_bsy", 64'(cu_sflags), 64'h1);
    check("full_head", 64'(cd_d0), 64'h11);
    uc_d0 = 32'h55; uc_mflags = 4'b0001;
    cyc();
    check("full_reject_occ", 64'(occ), 64'd4);
    check("full_hold_head", 64'(cd_d0), 64'h11);
    check("full_hold_mflags", 64'(cd_mflags), 64'h1);

    // Drain on consecutive cycles
    uc_mflags = 4'b0000; dc_sflags = 2'b00;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_d0_%0d", i), 64'(cd_d0), 64'(fill_vals[i]));
      check($sformatf("drain_vld_%0d", i), 64'(cd_mflags), 64'h1);
      cyc();
    end
    check("drain_empty_mflags", 64'(cd_mflags), 64'h0);
    check("drain_empty_occ", 64'(occ), 64'd0);
    check("drain_empty_d0", 64'(cd_d0), 64'h0);

    // again=1 is never stored
    uc_d0 = 32'hAA; uc_mflags = 4'b1001;
    cyc();
    check("again_occ", 64'(occ), 64'd0);
    check("again_mflags", 64'(cd_mflags), 64'h0);
    uc_mflags = 4'b1111;
    cyc();
    check("again_all_occ", 64'(occ), 64'd0);

    // Streaming 0..9 with first/last markers
    for (int k = 0; k < 10; k++) begin
      uc_d0 = 32'(k);
      uc_mflags = {1'b0, (k == 0), (k == 9), 1'b1};
      exp_mf = {1'b0, (k == 0), (k == 9), 1'b1};
      cyc();
      check($sformatf("stream_d0_%0d", k), 64'(cd_d0), 64'(k));
      check($sformatf("stream_mf_%0d", k), 64'(cd_mflags), 64'(exp_mf));
      check($sformatf("stream_occ_%0d", k), 64'(occ), 64'd1);
    end
    uc_mflags = 4'b0000;
    cyc();
    check("stream_end_occ", 64'(occ), 64'd0);

    // Abort with three entries held and a concurrent push
    dc_sflags = 2'b01;
    for (int i = 0; i < 3; i++) begin
      uc_d0 = 32'hA0 + 32'(i); uc_mflags = 4'b0001;
      cyc();
    end
    check("abort_pre_occ", 64'(occ), 64'd3);
    uc_d0 = 32'hA3; uc_mflags = 4'b0001; dc_sflags = 2'b11;
    #1;
    check("abort_cu_abt", 64'(cu_sflags), 64'h2);
    cyc();
    uc_mflags = 4'b0000; dc_sflags = 2'b00;
    #1;
    check("abort_occ", 64'(occ), 64'd0);
    check("abort_mflags", 64'(cd_mflags), 64'h0);
    check("abort_cu_sflags", 64'(cu_sflags), 64'h0);

    // Wrap: hold two entries, then ten push/pop cycles
    dc_sflags = 2'b01;
    uc_d0 = 32'hB0; uc_mflags = 4'b0001; cyc();
    uc_d0 = 32'hB1; cyc();
    check("wrap_pre_occ", 64'(occ), 64'd2);
    dc_sflags = 2'b00;
    for (int j = 0; j < 10; j++) begin
      uc_d0 = 32'hB2 + 32'(j); uc_mflags = 4'b0001;
      cyc();
      check($sformatf("wrap_d0_%0d", j), 64'(cd_d0), 64'(32'hB1 + 32'(j)));
      check($sformatf("wrap_occ_%0d", j), 64'(occ), 64'd2);
    end

    // Reset with two entries held and a push pending; push right after release
    dc_sflags = 2'b01; uc_d0 = 32'hC0; uc_mflags = 4'b0001; rst = 1'b1;
    cyc();
    check("rst_occ", 64'(occ), 64'd0);
    check("rst_mflags", 64'(cd_mflags), 64'h0);
    check("rst_d0", 64'(cd_d0), 64'h0);
    rst = 1'b0;
    cyc();
    check("post_rst_occ", 64'(occ), 64'd1);
    check("post_rst_d0", 64'(cd_d0), 64'hC0);
    check("post_rst_mflags", 64'(cd_mflags), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
